// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_sequencer
// Brief    : Releases NUM_OUT active-low resets in order, DELAY cycles apart.
//            Define RST_SEQ_ACK_WAIT_EN to wait for a per-stage ack (bounded
//            by TIMEOUT) between releases.
// Revision : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
    parameter int NUM_OUT = 4,
    parameter int DELAY   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic               clk,
    input  logic               i_rst_sync,
    input  logic               i_soft_rst,
    input  logic [NUM_OUT-1:0] i_ack,
    output logic [NUM_OUT-1:0] o_rst_n,
    output logic               o_done,
    output logic               o_timeout
);

    // One counter serves both the release delay and the ack timeout.
    localparam int c_CNT_MAX = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);
    localparam int c_IDX_W   = $clog2(NUM_OUT);

    localparam logic [c_CNT_W-1:0] c_DLY_LAST = c_CNT_W'(DELAY - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_OUT - 1);

    localparam logic [1:0] c_ST_DLY  = 2'd0;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [NUM_OUT-1:0] r_rst_n;
    logic               r_done;

`ifdef RST_SEQ_ACK_WAIT_EN

    localparam logic [1:0]         c_ST_ACK  = 2'd1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

    logic r_timeout;
    logic w_ack_hit;

    // Only the ack of the stage just released is ever looked at.
    assign w_ack_hit = i_ack[r_idx];

    always_ff @(posedge clk or negedge i_rst_sync) begin
        if (!i_rst_sync) begin
            r_state   <= c_ST_DLY;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rst_n   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (i_soft_rst) begin
            r_state   <= c_ST_DLY;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rst_n   <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_ST_DLY: begin
                    if (r_cnt == c_DLY_LAST) begin
                        r_cnt          <= '0;
                        r_rst_n[r_idx] <= 1'b1;
                        r_state        <= c_ST_ACK;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_ACK: begin
                    if (w_ack_hit || (r_cnt == c_TO_LAST)) begin
                        // A missing ack is flagged, then treated as if it came.
                        if (!w_ack_hit) begin
                            r_timeout <= 1'b1;
                        end
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + c_IDX_W'(1);
                            r_state <= c_ST_DLY;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_DLY;
                end
            endcase
        end
    end

    assign o_timeout = r_timeout;

`else

    logic w_unused_ack;

    assign w_unused_ack = ^i_ack;

    always_ff @(posedge clk or negedge i_rst_sync) begin
        if (!i_rst_sync) begin
            r_state <= c_ST_DLY;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else if (i_soft_rst) begin
            r_state <= c_ST_DLY;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_DLY: begin
                    if (r_cnt == c_DLY_LAST) begin
                        r_cnt          <= '0;
                        r_rst_n[r_idx] <= 1'b1;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_DLY;
                end
            endcase
        end
    end

    assign o_timeout = 1'b0;

`endif

    assign o_rst_n = r_rst_n;
    assign o_done  = r_done;

endmodule
`default_nettype wire

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 Parameter NUM_OUT, default 4: number of sequenced reset outputs, min 2.
REQ-002 Parameter DELAY, default 16: cycles each stage waits before release, min 2.
REQ-003 Parameter TIMEOUT, default 256: max cycles to wait for a stage ack, min 2.
REQ-004 clk  input  1  clock; the single clock domain of the block.
REQ-005 i_rst_sync  input  1  asynchronous, active-low reset; assertion is asynchronous, de-assertion is already synchronized to clk upstream.
REQ-006 i_soft_rst  input  1  synchronous, active-high single-cycle request to restart the sequence.
REQ-007 i_ack  input  NUM_OUT  per-stage "out of reset" acknowledge from the released block, level, synchronous to clk.
REQ-008 o_rst_n  output  NUM_OUT  sequenced active-low resets, bit 0 released first.
REQ-009 o_done  output  1  high when the whole sequence has completed.
REQ-010 o_timeout  output  1  sticky flag: at least one stage ack timed out.

Function
REQ-011 The FSM SHALL have states SEQ_DLY (counting DELAY for stage idx), SEQ_ACK (waiting for i_ack[idx]) and DONE.
REQ-012 After i_rst_sync de-asserts, the block SHALL enter SEQ_DLY with idx=0 and cnt=0 on the first clk edge.
REQ-013 In SEQ_DLY, cnt SHALL increment each cycle; on the edge where cnt==DELAY-1, o_rst_n[idx] SHALL go high and cnt SHALL clear.
REQ-014 Without ack wait, o_rst_n[k] SHALL rise exactly (k+1)*DELAY edges after the first post-reset edge; idx SHALL advance on the same edge.
REQ-015 Once released, o_rst_n[k] SHALL stay high until reset or i_soft_rst; outputs SHALL never release out of order.
REQ-016 o_done SHALL rise on the edge the sequence completes (REQ-014 last stage, or REQ-024 last ack) and hold until reset or i_soft_rst.
REQ-017 idx SHALL be sized ceil(log2(NUM_OUT)) bits and never exceed NUM_OUT-1; cnt SHALL be sized for max(DELAY, TIMEOUT) with no wrap.
REQ-018 i_soft_rst in any state SHALL, on the next edge, drive all o_rst_n low, clear o_done, o_timeout, idx and cnt, and enter SEQ_DLY.
REQ-019 i_soft_rst held high SHALL keep the block in that cleared state; counting SHALL start on the first edge with i_soft_rst low.
REQ-020 i_soft_rst and a release edge coinciding SHALL resolve in favour of i_soft_rst: no output rises.
REQ-021 i_ack bits for stages not yet released SHALL be ignored.

Reset
REQ-022 While i_rst_sync is low, o_rst_n SHALL be all zeros, o_done=0 and o_timeout=0 immediately (asynchronously), with state SEQ_DLY, idx=0, cnt=0.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence; releasing reset SHALL restart from stage 0 per REQ-012.

Configuration
REQ-024 With RST_SEQ_ACK_WAIT_EN defined: after releasing stage idx, the FSM SHALL enter SEQ_ACK and advance (to SEQ_DLY for idx+1, or DONE if last) on the edge i_ack[idx] is sampled high.
REQ-025 With RST_SEQ_ACK_WAIT_EN defined: if i_ack[idx] is not seen within TIMEOUT cycles in SEQ_ACK, o_timeout SHALL set and the FSM SHALL advance as if acked.
REQ-026 Without RST_SEQ_ACK_WAIT_EN: no SEQ_ACK state, i_ack is unused, o_timeout SHALL be tied 0, and timing follows REQ-014.

Verification
REQ-027 Defaults, no macro, ack unused: release reset -> o_rst_n goes 0001, 0011, 0111, 1111 at edges 16, 32, 48, 64; o_done rises at edge 64.
REQ-028 Macro on, i_ack[k] returned 5 cycles after each release -> o_rst_n[k+1] rises 5+16 cycles after o_rst_n[k]; o_done rises on the edge i_ack[3] is sampled high; o_timeout stays 0.
REQ-029 Macro on, i_ack[1] held low -> o_timeout sets 256 cycles after o_rst_n[1] rises; o_rst_n[2] rises 16 cycles later; the sequence completes.
REQ-030 i_soft_rst pulsed at edge 40 -> o_rst_n=0000 at edge 41; stage 0 re-released 16 cycles after the pulse clears.
REQ-031 i_rst_sync asserted mid-clock at edge 50 -> outputs 0000 without waiting for clk; after release, identical timing to REQ-027.
REQ-032 i_soft_rst coincident with the stage-2 release edge -> o_rst_n[2] never rises; all outputs read 0000 on the next edge.
